// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor.
// Each clock, one DIGIT-bit adder slice with a registered carry handles one digit,
// so a WIDTH-bit operation takes N = WIDTH/DIGIT cycles.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN enables signed-overflow output ovf_o.
//
// Handshake: start_i is sampled only while the block can accept a request (IDLE or DONE).
// busy_o is high while the operation runs. done_o pulses for one cycle, and in that
// cycle sum_o/cout_o/ovf_o first show the new result. Results are held until the next done_o.
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_r, b_r, res_r;
  logic              c_r;
  logic [CW-1:0]     count_r;
  logic [DIGIT:0]    slice;
  logic [WIDTH-1:0]  res_next;
  logic              accept;
  logic              last;

  assign accept  = start_i && (state_q == IDLE || state_q == DONE);
  assign last    = (count_r == CW'(N - 1));
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

  // One digit slice: low digits of both operands plus the carry held from the previous digit
  always_comb begin
    slice    = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
    res_next = WIDTH'({slice[DIGIT-1:0], res_r} >> DIGIT);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, digit-serial datapath and result registers.
  // Subtraction is done as a + ~b + ~borrow, so inversion happens once at accept.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      c_r     <= 1'b0;
      count_r <= '0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
    end else if (accept) begin
      a_r     <= a_i;
      b_r     <= sub_i ? ~b_i : b_i;
      c_r     <= sub_i ? ~cin_i : cin_i;
      res_r   <= '0;
      count_r <= '0;
    end else if (state_q == RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      c_r     <= slice[DIGIT];
      res_r   <= res_next;
      count_r <= count_r + CW'(1);
      if (last) begin
        sum_o  <= res_next;
        cout_o <= slice[DIGIT];
      end
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic a_msb_r, b_msb_r, ovf_r;

  // Signed overflow: operands share a sign that the result does not (B after inversion)
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_msb_r <= a_i[WIDTH-1];
      b_msb_r <= sub_i ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_r <= (a_msb_r == b_msb_r) && (res_next[WIDTH-1] != a_msb_r);
    end
  end

  assign ovf_o = ovf_r;
`else
  assign ovf_o = 1'b0;
`endif

endmodule
